// File: rtl/img_buf_pkg.sv
// Shared types and defaults for the image frame buffer.
package img_buf_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fb_state_t;

    localparam int unsigned DefaultPixW  = 8;
    localparam int unsigned DefaultDepth = 8192;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
module bram_sdp #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_data_q;

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/image_frame_buffer.sv
// Frame store: streamed pixel writes at an auto-incrementing pointer, random-access reads.
// Define FB_OUT_REG_EN to add an output register after the RAM (read latency 2).
module image_frame_buffer
    import img_buf_pkg::*;
#(
    parameter int unsigned PIX_W     = DefaultPixW,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              new_data,
    input  logic [PIX_W-1:0]  image_in,
    output logic              wr_ready,
    output logic [ADDR_W:0]   wr_count,
    output logic              frame_done,
    output logic              frame_full,
    output logic              overflow,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address_read,
    output logic [PIX_W-1:0]  image_out,
    output logic              rd_valid
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam bit                WrapEn   = (WRAP_MODE != 0);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign wr_ready = (state_q == FILL);
    // frame_start reopens the frame, so a concurrent beat is accepted even when full.
    assign wr_en    = !reset && new_data && (frame_start || wr_ready);
    assign wr_addr  = frame_start ? '0 : wr_ptr_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_count_d   = wr_count_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;

        if (frame_start) begin
            state_d    = FILL;
            wr_ptr_d   = '0;
            wr_count_d = '0;
            overflow_d = 1'b0;
        end

        if (wr_en) begin
            if (wr_addr == LastAddr) begin
                frame_done_d = 1'b1;
                wr_ptr_d     = '0;
                if (WrapEn) begin
                    wr_count_d = '0;
                end else begin
                    wr_count_d = DepthCnt;
                    state_d    = FULL;
                end
            end else begin
                wr_ptr_d   = wr_addr + 1'b1;
                wr_count_d = {1'b0, wr_addr} + 1'b1;
            end
        end else if (new_data && !frame_start && !wr_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            wr_count_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_count_q   <= wr_count_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_count   = wr_count_q;
    assign frame_done = frame_done_q;
    assign frame_full = !WrapEn && (state_q == FULL);
    assign overflow   = overflow_q;

    // Read path
    logic             rd_in_range;
    logic             bram_rd_en;
    logic [PIX_W-1:0] bram_rd_data;
    logic             rd_mask_q, rd_mask_d;
    logic             rd_valid1_q, rd_valid1_d;
    logic [PIX_W-1:0] rd_stage1;

    assign rd_in_range = ({1'b0, address_read} < DepthCnt);
    assign bram_rd_en  = !reset && rd_en && rd_in_range;

    bram_sdp #(
        .PIX_W  (PIX_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (image_in),
        .rd_en_i   (bram_rd_en),
        .rd_addr_i (address_read),
        .rd_data_o (bram_rd_data)
    );

    // The mask forces zero after reset and for out-of-range reads; the RAM register
    // and the mask both only move on rd_en, so idle cycles hold the last value.
    always_comb begin
        rd_mask_d   = rd_mask_q;
        rd_valid1_d = rd_en;
        if (rd_en) begin
            rd_mask_d = !rd_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_mask_q   <= 1'b1;
            rd_valid1_q <= 1'b0;
        end else begin
            rd_mask_q   <= rd_mask_d;
            rd_valid1_q <= rd_valid1_d;
        end
    end

    assign rd_stage1 = rd_mask_q ? '0 : bram_rd_data;

`ifdef FB_OUT_REG_EN
    logic [PIX_W-1:0] out_q, out_d;
    logic             rd_valid2_q, rd_valid2_d;

    always_comb begin
        out_d       = rd_valid1_q ? rd_stage1 : out_q;
        rd_valid2_d = rd_valid1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            rd_valid2_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            rd_valid2_q <= rd_valid2_d;
        end
    end

    assign image_out = out_q;
    assign rd_valid  = rd_valid2_q;
`else
    assign image_out = rd_stage1;
    assign rd_valid  = rd_valid1_q;
`endif

endmodule

// File: tb/tb_image_frame_buffer.sv
// Randomised and directed bench for image_frame_buffer against a behavioural frame-store model.
module tb_image_frame_buffer;

    localparam int N = 3;
`ifdef FB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic int depth_of(input int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic int wrap_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       fs [N];
    logic       nd [N];
    logic [7:0] din [N];
    logic       re [N];
    logic [3:0] ra [N];
    logic       wr_ready [N];
    logic [4:0] wr_count [N];
    logic       frame_done [N];
    logic       frame_full [N];
    logic       overflow [N];
    logic [7:0] image_out [N];
    logic       rd_valid [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        image_frame_buffer #(
            .PIX_W     (8),
            .DEPTH     ((g == 2) ? 12 : 16),
            .WRAP_MODE ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .frame_start  (fs[g]),
            .new_data     (nd[g]),
            .image_in     (din[g]),
            .wr_ready     (wr_ready[g]),
            .wr_count     (wr_count[g]),
            .frame_done   (frame_done[g]),
            .frame_full   (frame_full[g]),
            .overflow     (overflow[g]),
            .rd_en        (re[g]),
            .address_read (ra[g]),
            .image_out    (image_out[g]),
            .rd_valid     (rd_valid[g])
        );
    end

    // Reference model: what each frame store should hold and report.
    int m_mem   [N][16];
    bit m_known [N][16];
    int m_cnt   [N];
    bit m_full  [N];
    bit m_ovf   [N];
    bit m_done  [N];
    int m_out   [N];
    bit m_out_k [N];
    bit m_valid [N];
    bit s_v     [N];
    int s_d     [N];
    bit s_k     [N];
    int done_seen [N];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int  rv;
        bit  rk;
        int  a;
        rv = 0;
        rk = 1'b1;
        if (re[i] && (int'(ra[i]) < depth_of(i))) begin
            rv = m_mem[i][ra[i]];
            rk = m_known[i][ra[i]];
        end
        if (reset) begin
            m_valid[i] = 1'b0; m_out[i] = 0; m_out_k[i] = 1'b1;
            s_v[i] = 1'b0; s_d[i] = 0; s_k[i] = 1'b1;
        end else if (LAT == 2) begin
            m_valid[i] = s_v[i];
            if (s_v[i]) begin
                m_out[i] = s_d[i]; m_out_k[i] = s_k[i];
            end
            s_v[i] = re[i];
            if (re[i]) begin
                s_d[i] = rv; s_k[i] = rk;
            end
        end else begin
            m_valid[i] = re[i];
            if (re[i]) begin
                m_out[i] = rv; m_out_k[i] = rk;
            end
        end

        m_done[i] = 1'b0;
        if (reset) begin
            m_cnt[i] = 0; m_full[i] = 1'b0; m_ovf[i] = 1'b0;
        end else begin
            if (fs[i]) begin
                m_cnt[i] = 0; m_full[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            if (nd[i] && !m_full[i]) begin
                a = m_cnt[i];
                m_mem[i][a] = int'(din[i]);
                m_known[i][a] = 1'b1;
                m_cnt[i] = a + 1;
                if (m_cnt[i] == depth_of(i)) begin
                    m_done[i] = 1'b1;
                    if (wrap_of(i) != 0) m_cnt[i] = 0;
                    else m_full[i] = 1'b1;
                end
            end else if (nd[i]) begin
                m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input int i);
        check($sformatf("u%0d.wr_ready", i), 32'(wr_ready[i]), 32'(!m_full[i]));
        check($sformatf("u%0d.wr_count", i), 32'(wr_count[i]), m_cnt[i]);
        check($sformatf("u%0d.frame_done", i), 32'(frame_done[i]), 32'(m_done[i]));
        check($sformatf("u%0d.frame_full", i), 32'(frame_full[i]), 32'(m_full[i]));
        check($sformatf("u%0d.overflow", i), 32'(overflow[i]), 32'(m_ovf[i]));
        check($sformatf("u%0d.rd_valid", i), 32'(rd_valid[i]), 32'(m_valid[i]));
        if (m_out_k[i]) begin
            check($sformatf("u%0d.image_out", i), 32'(image_out[i]), m_out[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        #1;
        for (int i = 0; i < N; i++) begin
            check_all(i);
            if (frame_done[i] === 1'b1) done_seen[i]++;
        end
    endtask

    task automatic idle_all();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            fs[i] = 1'b0; nd[i] = 1'b0; re[i] = 1'b0; din[i] = '0; ra[i] = '0;
        end
    endtask

    task automatic write_px(input int i, input int v);
        nd[i] = 1'b1; din[i] = 8'(v);
        tick();
        nd[i] = 1'b0;
    endtask

    task automatic frame_restart(input int i);
        fs[i] = 1'b1;
        tick();
        fs[i] = 1'b0;
    endtask

    // Issue one read and advance until its data is on image_out.
    task automatic read_px(input int i, input int a, input int exp, input string tag);
        re[i] = 1'b1; ra[i] = 4'(a);
        tick();
        re[i] = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        check(tag, 32'(image_out[i]), exp);
        check({tag, ".valid"}, 32'(rd_valid[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_full[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
            m_out[i] = 0; m_out_k[i] = 0; m_valid[i] = 0;
            s_v[i] = 0; s_d[i] = 0; s_k[i] = 0; done_seen[i] = 0;
            for (int a = 0; a < 16; a++) begin
                m_mem[i][a] = 0; m_known[i][a] = 1'b0;
            end
        end
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        check("reset.wr_count", 32'(wr_count[0]), 32'd0);
        check("reset.wr_ready", 32'(wr_ready[0]), 32'd1);
        check("reset.image_out", 32'(image_out[0]), 32'd0);
        reset = 1'b0;
        tick();

        // Basic write then read back
        write_px(0, 30); write_px(0, 80); write_px(0, 70); write_px(0, 20);
        check("t1.wr_count", 32'(wr_count[0]), 32'd4);
        read_px(0, 0, 30, "t1.rd0");
        read_px(0, 1, 80, "t1.rd1");
        read_px(0, 2, 70, "t1.rd2");
        read_px(0, 3, 20, "t1.rd3");

        // Fill a whole frame in stop mode, then overrun it
        frame_restart(0);
        done_seen[0] = 0;
        for (int k = 0; k < 16; k++) write_px(0, 100 + k);
        check("t2.done_pulses", 32'(done_seen[0]), 32'd1);
        check("t2.frame_full", 32'(frame_full[0]), 32'd1);
        check("t2.wr_ready", 32'(wr_ready[0]), 32'd0);
        check("t2.wr_count", 32'(wr_count[0]), 32'd16);
        write_px(0, 8'hEE);
        check("t2.overflow", 32'(overflow[0]), 32'd1);
        read_px(0, 0, 100, "t2.addr0_kept");

        // frame_start plus a beat while full
        fs[0] = 1'b1; nd[0] = 1'b1; din[0] = 8'hAA;
        tick();
        fs[0] = 1'b0; nd[0] = 1'b0;
        check("t4.overflow", 32'(overflow[0]), 32'd0);
        check("t4.wr_ready", 32'(wr_ready[0]), 32'd1);
        check("t4.wr_count", 32'(wr_count[0]), 32'd1);
        read_px(0, 0, 8'hAA, "t4.addr0");

        // Same-cycle write and read of one address returns the old pixel
        for (int k = 1; k < 5; k++) write_px(0, k);
        write_px(0, 8'h11);
        frame_restart(0);
        for (int k = 0; k < 5; k++) write_px(0, 40 + k);
        nd[0] = 1'b1; din[0] = 8'h55; re[0] = 1'b1; ra[0] = 4'd5;
        tick();
        nd[0] = 1'b0; re[0] = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        check("t5.read_first", 32'(image_out[0]), 32'h11);
        read_px(0, 5, 8'h55, "t5.new");

        // Circular mode
        done_seen[1] = 0;
        for (int k = 0; k < 20; k++) write_px(1, k);
        check("t3.done_pulses", 32'(done_seen[1]), 32'd1);
        check("t3.frame_full", 32'(frame_full[1]), 32'd0);
        check("t3.wr_count", 32'(wr_count[1]), 32'd4);
        for (int a = 0; a < 4; a++) read_px(1, a, 16 + a, $sformatf("t3.rd%0d", a));
        read_px(1, 4, 4, "t3.rd4");

        // Out-of-range read on the non-power-of-two frame
        for (int k = 0; k < 12; k++) write_px(2, 200 + k);
        check("oor.frame_full", 32'(frame_full[2]), 32'd1);
        read_px(2, 11, 211, "oor.last");
        read_px(2, 13, 0, "oor.zero");

        // Reset mid-frame with a read pending
        frame_restart(0);
        write_px(0, 9); write_px(0, 8);
        reset = 1'b1; re[0] = 1'b1; ra[0] = 4'd0;
        tick();
        reset = 1'b0; re[0] = 1'b0;
        check("t6.rd_valid", 32'(rd_valid[0]), 32'd0);
        check("t6.wr_count", 32'(wr_count[0]), 32'd0);
        write_px(0, 8'h3C);
        check("t6.wr_count1", 32'(wr_count[0]), 32'd1);
        read_px(0, 0, 8'h3C, "t6.addr0");

        // Random traffic on all three instances
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                fs[i]  = ($urandom_range(0, 39) == 0);
                nd[i]  = ($urandom_range(0, 3) != 0);
                din[i] = 8'($urandom);
                re[i]  = $urandom_range(0, 1) == 1;
                ra[i]  = 4'($urandom_range(0, 15));
            end
            tick();
        end
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
